cache: RTL and testbench
========================

CACHE -- requirements
Module: cache

Interface
REQ-001 SHALL have parameters N_SECTORS=2 (ways), N_LINES=2 (sets per way), N_ELEMENTS=2 (words per line), N_BYTES=4 (bytes per word), VA_WIDTH=8 and PA_WIDTH=8; OFFSET_W=clog2(N_ELEMENTS), INDEX_W=clog2(N_LINES), TAG_W=PA_WIDTH-OFFSET_W, ELEM_W=8*N_BYTES, LINE_W=N_ELEMENTS*ELEM_W.
REQ-002 SHALL have the ports below, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- rnd  in  INDEX_W  random value used for victim selection.
- i_is_load / i_is_store  in  1  load or store request.
- i_va_addr  in  VA_WIDTH  virtual word address, supplying index and offset.
- i_pa_addr  in  PA_WIDTH  physical word address, supplying the tag.
- i_write_data  in  ELEM_W  store data.
- o_hit  out  1  request hits.
- o_stall  out  1  requester must hold.
- o_read_data  out  ELEM_W  load data.
- o_mem_enable  out  1  memory request strobe.
- o_mem_type  out  1  0=line read, 1=line write-back.
- o_mem_ack  out  1  fill accepted.
- o_mem_addr  out  PA_WIDTH  line-aligned address.
- o_mem_data  out  LINE_W  write-back line.
- i_mem_enable  in  1  fill valid.
- i_mem_data  in  LINE_W  fill line.
- i_mem_addr  in  PA_WIDTH  fill address.

Function
REQ-003 SHALL hold per-way, per-set arrays tag[N_SECTORS][N_LINES], memory (line data), valid_bit and dirty_bit, plus a state register named state.
REQ-004 SHALL derive offset=va[OFFSET_W-1:0], index=va[OFFSET_W+INDEX_W-1:OFFSET_W] and tag=pa[PA_WIDTH-1:OFFSET_W]. Element e of a line SHALL occupy bits [e*ELEM_W +: ELEM_W].
REQ-005 SHALL compute o_hit combinationally: (i_is_load|i_is_store) and state==IDLE and some way at index is valid with a matching tag.
REQ-006 On a load hit, o_read_data SHALL be the addressed element in the same cycle; otherwise o_read_data SHALL be 0.
REQ-007 On a store hit at the clock edge, the addressed element SHALL be written with i_write_data and the line's dirty bit set.
REQ-008 o_stall SHALL equal ((i_is_load|i_is_store) and not o_hit) or state!=IDLE.
REQ-009 FSM states and transitions:
- IDLE: on a miss, latch index, tag and victim way. Go to WB if the victim is valid and dirty, else to REQ.
- WB: drive one cycle with o_mem_enable=1, o_mem_type=1, o_mem_addr={victim tag, OFFSET_W zeros} and o_mem_data=victim line; no response is awaited; go to REQ.
- REQ: drive one cycle with o_mem_enable=1, o_mem_type=0, o_mem_addr={miss tag, zeros}; go to FILL.
- FILL: wait for i_mem_enable with i_mem_addr[PA_WIDTH-1:OFFSET_W]==latched tag. Non-matching fills SHALL be ignored. On a match, write the line into the victim way, set valid, clear dirty, pulse o_mem_ack high for exactly the next cycle, and go to IDLE.
REQ-010 Store data SHALL NOT be buffered across a miss; the requester re-presents the store, which then hits. The miss SHALL complete even if the request is withdrawn.
REQ-011 Victim selection SHALL pick the lowest-numbered invalid way at the index; if all ways are valid, the policy in REQ-015 applies.
REQ-012 Outside WB/REQ, o_mem_enable, o_mem_type, o_mem_addr and o_mem_data SHALL be 0.

Reset
REQ-013 When rst=1 at a clock edge, the cache SHALL clear every valid and dirty bit, set state=IDLE and clear o_mem_ack. Tag and data arrays are not cleared.
REQ-014 Reset mid-miss SHALL abandon the transaction. All outputs SHALL be 0 during and after reset until a request arrives.

Configuration
REQ-015 With CACHE_RAND_REPL_EN defined, a full set's victim SHALL be rnd modulo N_SECTORS. Without it, rnd SHALL be ignored and a per-set round-robin pointer SHALL be used; the pointer resets to 0 and advances by one on each fill.

Verification (default parameters; tag[0][0]=07, valid, line {AAAAAAAA,BBBBBBBB} preloaded)
REQ-016 Load va=01, pa=0F -> hit=1, stall=0, read_data=AAAAAAAA. Load va=00 -> read_data=BBBBBBBB.
REQ-017 Load va=03, pa=05 -> stall=1, then one cycle with mem_enable=1, type=0, addr=04. A fill {CCCCCCCC,DDDDDDDD} with addr=05 -> mem_ack pulses, then hit=1 and read_data=CCCCCCCC.
REQ-018 Store va=00, pa=0F, data=11111111 -> hit=1. Line becomes {AAAAAAAA,11111111} with dirty=1.
REQ-019 Load va=01, pa=A0 -> fills way 1 set 0 (invalid way) with no write-back. A fill {22222222,33333333} -> read_data=22222222.
REQ-020 With the macro defined and rnd=0, store miss va=00, pa=A4 -> write-back with type=1, addr=0E, data {AAAAAAAA,11111111}, then read addr=A4. A fill arriving with addr=B0 first -> ignored, no ack.
REQ-021 Assert rst during FILL -> state=IDLE, all valid bits 0, and the next load misses.

Source files
------------

// File: rtl/cache.sv
// Set-associative write-back cache with a single outstanding line miss.
// Define CACHE_RAND_REPL_EN to pick full-set victims from rnd; default is per-set round-robin.
module cache #(
  parameter int N_SECTORS  = 2,
  parameter int N_LINES    = 2,
  parameter int N_ELEMENTS = 2,
  parameter int N_BYTES    = 4,
  parameter int VA_WIDTH   = 8,
  parameter int PA_WIDTH   = 8,
  localparam int OFFSET_W  = $clog2(N_ELEMENTS),
  localparam int INDEX_W   = $clog2(N_LINES),
  localparam int TAG_W     = PA_WIDTH - OFFSET_W,
  localparam int ELEM_W    = 8 * N_BYTES,
  localparam int LINE_W    = N_ELEMENTS * ELEM_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rnd,
  input  logic                i_is_load,
  input  logic                i_is_store,
  input  logic [VA_WIDTH-1:0] i_va_addr,
  input  logic [PA_WIDTH-1:0] i_pa_addr,
  input  logic [ELEM_W-1:0]   i_write_data,
  output logic                o_hit,
  output logic                o_stall,
  output logic [ELEM_W-1:0]   o_read_data,
  output logic                o_mem_enable,
  output logic                o_mem_type,
  output logic                o_mem_ack,
  output logic [PA_WIDTH-1:0] o_mem_addr,
  output logic [LINE_W-1:0]   o_mem_data,
  input  logic                i_mem_enable,
  input  logic [LINE_W-1:0]   i_mem_data,
  input  logic [PA_WIDTH-1:0] i_mem_addr
);

  localparam int WAY_W = (N_SECTORS > 1) ? $clog2(N_SECTORS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REQ, FILL} state_t;
  state_t state, state_next;

  logic [TAG_W-1:0]    tag       [N_SECTORS][N_LINES];
  logic [LINE_W-1:0]   memory    [N_SECTORS][N_LINES];
  logic                valid_bit [N_SECTORS][N_LINES];
  logic                dirty_bit [N_SECTORS][N_LINES];
  logic [WAY_W-1:0]    rr_ptr    [N_LINES];

  logic [OFFSET_W-1:0] req_offset;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;
  logic                req_any, active, lookup_hit, miss, fill_match;
  logic                found_invalid;
  logic [WAY_W-1:0]    hit_way, victim_sel;
  logic [INDEX_W-1:0]  miss_index;
  logic [TAG_W-1:0]    miss_tag;
  logic [WAY_W-1:0]    victim_way;
  logic [ELEM_W-1:0]   hit_elem;
  logic                unused_bits;

  assign req_offset  = i_va_addr[OFFSET_W-1:0];
  assign req_index   = i_va_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_tag     = i_pa_addr[PA_WIDTH-1:OFFSET_W];
  assign req_any     = i_is_load | i_is_store;
  assign active      = !rst;
  assign unused_bits = ^{i_va_addr[VA_WIDTH-1:OFFSET_W+INDEX_W], i_pa_addr[OFFSET_W-1:0],
                         i_mem_addr[OFFSET_W-1:0], rnd};

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < N_SECTORS; w++) begin
      if (!lookup_hit && valid_bit[w][req_index] && (tag[w][req_index] == req_tag)) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way wins; a full set falls back to the replacement policy.
  always_comb begin
    found_invalid = 1'b0;
    victim_sel    = '0;
    for (int w = 0; w < N_SECTORS; w++) begin
      if (!found_invalid && !valid_bit[w][req_index]) begin
        found_invalid = 1'b1;
        victim_sel    = WAY_W'(w);
      end
    end
    if (!found_invalid) begin
`ifdef CACHE_RAND_REPL_EN
      victim_sel = WAY_W'(32'(rnd) % N_SECTORS);
`else
      victim_sel = rr_ptr[req_index];
`endif
    end
  end

  assign hit_elem    = memory[hit_way][req_index][req_offset*ELEM_W +: ELEM_W];
  assign o_hit       = active && req_any && (state == IDLE) && lookup_hit;
  assign o_read_data = (o_hit && i_is_load) ? hit_elem : '0;
  assign o_stall     = active && ((req_any && !o_hit) || (state != IDLE));
  assign miss        = active && req_any && (state == IDLE) && !lookup_hit;
  assign fill_match  = i_mem_enable && (i_mem_addr[PA_WIDTH-1:OFFSET_W] == miss_tag);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    o_mem_enable = 1'b0;
    o_mem_type   = 1'b0;
    o_mem_addr   = '0;
    o_mem_data   = '0;
    unique case (state)
      IDLE: begin
        if (miss)
          state_next = (valid_bit[victim_sel][req_index] && dirty_bit[victim_sel][req_index]) ? WB : REQ;
      end
      WB: begin
        o_mem_enable = active;
        o_mem_type   = active;
        o_mem_addr   = active ? {tag[victim_way][miss_index], {OFFSET_W{1'b0}}} : '0;
        o_mem_data   = active ? memory[victim_way][miss_index] : '0;
        state_next   = REQ;
      end
      REQ: begin
        o_mem_enable = active;
        o_mem_addr   = active ? {miss_tag, {OFFSET_W{1'b0}}} : '0;
        state_next   = FILL;
      end
      FILL: begin
        if (fill_match) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line state and replacement pointers; reset abandons any in-flight miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_mem_ack <= 1'b0;
      for (int w = 0; w < N_SECTORS; w++) begin
        for (int l = 0; l < N_LINES; l++) begin
          valid_bit[w][l] <= 1'b0;
          dirty_bit[w][l] <= 1'b0;
        end
      end
      for (int l = 0; l < N_LINES; l++) rr_ptr[l] <= '0;
    end else begin
      o_mem_ack <= (state == FILL) && fill_match;
      if (o_hit && i_is_store) dirty_bit[hit_way][req_index] <= 1'b1;
      if ((state == FILL) && fill_match) begin
        valid_bit[victim_way][miss_index] <= 1'b1;
        dirty_bit[victim_way][miss_index] <= 1'b0;
        rr_ptr[miss_index] <= (rr_ptr[miss_index] == WAY_W'(N_SECTORS - 1)) ? '0
                              : rr_ptr[miss_index] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss) begin
      miss_index <= req_index;
      miss_tag   <= req_tag;
      victim_way <= victim_sel;
    end
    if (o_hit && i_is_store)
      memory[hit_way][req_index][req_offset*ELEM_W +: ELEM_W] <= i_write_data;
    if ((state == FILL) && fill_match) begin
      memory[victim_way][miss_index] <= i_mem_data;
      tag[victim_way][miss_index]    <= miss_tag;
    end
  end

endmodule

// File: tb/tb_cache.sv
// Scoreboard bench for cache: expected memory transactions and load data are queued at stimulus time.
module tb_cache;
  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  rnd;
  logic        i_is_load, i_is_store;
  logic [7:0]  i_va_addr, i_pa_addr;
  logic [31:0] i_write_data;
  logic        o_hit, o_stall;
  logic [31:0] o_read_data;
  logic        o_mem_enable, o_mem_type, o_mem_ack;
  logic [7:0]  o_mem_addr;
  logic [63:0] o_mem_data;
  logic        i_mem_enable;
  logic [63:0] i_mem_data;
  logic [7:0]  i_mem_addr;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        typ;
    logic [7:0]  addr;
    logic [63:0] data;
  } mem_txn_t;

  mem_txn_t    mem_q[$];
  logic [31:0] rd_q[$];

  cache dut (
    .clk(clk), .rst(rst), .rnd(rnd),
    .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_va_addr(i_va_addr), .i_pa_addr(i_pa_addr), .i_write_data(i_write_data),
    .o_hit(o_hit), .o_stall(o_stall), .o_read_data(o_read_data),
    .o_mem_enable(o_mem_enable), .o_mem_type(o_mem_type), .o_mem_ack(o_mem_ack),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data), .i_mem_addr(i_mem_addr)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_is_load = 1'b0; i_is_store = 1'b0; i_va_addr = '0; i_pa_addr = '0;
    i_write_data = '0; i_mem_enable = 1'b0; i_mem_data = '0; i_mem_addr = '0; rnd = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic ld, input logic [7:0] va, input logic [7:0] pa,
                           input logic [31:0] wd);
    i_is_load = ld; i_is_store = !ld; i_va_addr = va; i_pa_addr = pa; i_write_data = wd;
  endtask

  task automatic wait_mem(output logic seen, output mem_txn_t obs);
    seen = 1'b0;
    obs  = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (o_mem_enable === 1'b1) begin
        seen = 1'b1;
        obs  = {o_mem_type, o_mem_addr, o_mem_data};
      end
    end
  endtask

  task automatic fill(input logic [7:0] addr, input logic [63:0] data);
    next_cycle();
    i_mem_enable = 1'b1; i_mem_addr = addr; i_mem_data = data;
    next_cycle();
    i_mem_enable = 1'b0; i_mem_addr = '0; i_mem_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({o_hit, o_stall, o_read_data, o_mem_enable, o_mem_type, o_mem_addr, o_mem_data, o_mem_ack} !== '0) begin
      failures++;
      $display("FAIL rst_outputs got hit=%b stall=%b rd=%h en=%b ty=%b addr=%h ack=%b want all 0",
               o_hit, o_stall, o_read_data, o_mem_enable, o_mem_type, o_mem_addr, o_mem_ack);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_hit, o_stall, o_read_data, o_mem_enable, o_mem_type, o_mem_addr, o_mem_data, o_mem_ack} !== '0) begin
      failures++;
      $display("FAIL post_rst_outputs got hit=%b stall=%b rd=%h en=%b ack=%b want all 0",
               o_hit, o_stall, o_read_data, o_mem_enable, o_mem_ack);
    end
  endtask

  task automatic test_cold_fill();
    logic seen;
    mem_txn_t obs, want;
    next_cycle();
    drive_req(1'b1, 8'h00, 8'h0E, 32'h0);
    mem_q.push_back({1'b0, 8'h0E, 64'h0});
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b1 || o_hit !== 1'b0 || o_read_data !== 32'h0) begin
      failures++;
      $display("FAIL cold_miss got stall=%b hit=%b rd=%h want 1 0 0", o_stall, o_hit, o_read_data);
    end
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '1;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr) begin
      failures++;
      $display("FAIL cold_req seen=%b got ty=%b addr=%h want ty=%b addr=%h", seen, obs.typ, obs.addr, want.typ, want.addr);
    end
    fill(8'h0E, 64'hAAAAAAAA_BBBBBBBB);
    rd_q.push_back(32'hBBBBBBBB);
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b1) begin failures++; $display("FAIL cold_ack got=%b want=1", o_mem_ack); end
    checks++;
    if (o_hit !== 1'b1) begin failures++; $display("FAIL cold_rehit got=%b want=1", o_hit); end
    want.data[31:0] = rd_q.pop_front();
    checks++;
    if (o_read_data !== want.data[31:0]) begin
      failures++; $display("FAIL cold_data got=%h want=%h", o_read_data, want.data[31:0]);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b0) begin failures++; $display("FAIL cold_ack_pulse got=%b want=0", o_mem_ack); end
    idle_inputs();
  endtask

  task automatic test_load_hit();
    logic [31:0] want;
    next_cycle();
    drive_req(1'b1, 8'h01, 8'h0F, 32'h0);
    rd_q.push_back(32'hAAAAAAAA);
    @(negedge clk);
    checks++;
    if (o_hit !== 1'b1 || o_stall !== 1'b0) begin
      failures++; $display("FAIL hit_flags got hit=%b stall=%b want 1 0", o_hit, o_stall);
    end
    want = rd_q.pop_front();
    checks++;
    if (o_read_data !== want) begin failures++; $display("FAIL hit_elem1 got=%h want=%h", o_read_data, want); end
    next_cycle();
    drive_req(1'b1, 8'h00, 8'h0F, 32'h0);
    rd_q.push_back(32'hBBBBBBBB);
    @(negedge clk);
    want = rd_q.pop_front();
    checks++;
    if (o_read_data !== want) begin failures++; $display("FAIL hit_elem0 got=%h want=%h", o_read_data, want); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (o_read_data !== 32'h0 || o_stall !== 1'b0 || o_hit !== 1'b0) begin
      failures++; $display("FAIL idle_out got rd=%h stall=%b hit=%b want 0", o_read_data, o_stall, o_hit);
    end
  endtask

  task automatic test_miss_fill();
    logic seen;
    mem_txn_t obs, want;
    logic [31:0] wrd;
    next_cycle();
    drive_req(1'b1, 8'h03, 8'h05, 32'h0);
    mem_q.push_back({1'b0, 8'h04, 64'h0});
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b1 || o_hit !== 1'b0) begin
      failures++; $display("FAIL miss_stall got stall=%b hit=%b want 1 0", o_stall, o_hit);
    end
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '1;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr) begin
      failures++;
      $display("FAIL miss_req seen=%b got ty=%b addr=%h want ty=%b addr=%h", seen, obs.typ, obs.addr, want.typ, want.addr);
    end
    fill(8'h05, 64'hCCCCCCCC_DDDDDDDD);
    rd_q.push_back(32'hCCCCCCCC);
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b1 || o_hit !== 1'b1) begin
      failures++; $display("FAIL miss_ack got ack=%b hit=%b want 1 1", o_mem_ack, o_hit);
    end
    wrd = rd_q.pop_front();
    checks++;
    if (o_read_data !== wrd) begin failures++; $display("FAIL miss_data got=%h want=%h", o_read_data, wrd); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b0) begin failures++; $display("FAIL miss_ack_pulse got=%b want=0", o_mem_ack); end
    idle_inputs();
  endtask

  task automatic test_store_hit();
    logic [31:0] want;
    next_cycle();
    drive_req(1'b0, 8'h00, 8'h0F, 32'h11111111);
    @(negedge clk);
    checks++;
    if (o_hit !== 1'b1 || o_stall !== 1'b0 || o_read_data !== 32'h0) begin
      failures++; $display("FAIL store_hit got hit=%b stall=%b rd=%h want 1 0 0", o_hit, o_stall, o_read_data);
    end
    next_cycle();
    drive_req(1'b1, 8'h00, 8'h0F, 32'h0);
    rd_q.push_back(32'h11111111);
    @(negedge clk);
    want = rd_q.pop_front();
    checks++;
    if (o_read_data !== want) begin failures++; $display("FAIL store_elem0 got=%h want=%h", o_read_data, want); end
    next_cycle();
    drive_req(1'b1, 8'h01, 8'h0F, 32'h0);
    rd_q.push_back(32'hAAAAAAAA);
    @(negedge clk);
    want = rd_q.pop_front();
    checks++;
    if (o_read_data !== want) begin failures++; $display("FAIL store_elem1 got=%h want=%h", o_read_data, want); end
    idle_inputs();
  endtask

  task automatic test_invalid_way();
    logic seen;
    mem_txn_t obs, want;
    logic [31:0] wrd;
    next_cycle();
    drive_req(1'b1, 8'h01, 8'hA0, 32'h0);
    mem_q.push_back({1'b0, 8'hA0, 64'h0});
    @(negedge clk);
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '1;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr) begin
      failures++;
      $display("FAIL inv_req seen=%b got ty=%b addr=%h want ty=%b addr=%h", seen, obs.typ, obs.addr, want.typ, want.addr);
    end
    fill(8'hA0, 64'h22222222_33333333);
    rd_q.push_back(32'h22222222);
    @(negedge clk);
    wrd = rd_q.pop_front();
    checks++;
    if (o_mem_ack !== 1'b1 || o_read_data !== wrd) begin
      failures++; $display("FAIL inv_fill got ack=%b rd=%h want 1 %h", o_mem_ack, o_read_data, wrd);
    end
    next_cycle();
    drive_req(1'b1, 8'h01, 8'h0F, 32'h0);
    rd_q.push_back(32'hAAAAAAAA);
    @(negedge clk);
    wrd = rd_q.pop_front();
    checks++;
    if (o_hit !== 1'b1 || o_read_data !== wrd) begin
      failures++; $display("FAIL inv_way0_kept got hit=%b rd=%h want 1 %h", o_hit, o_read_data, wrd);
    end
    idle_inputs();
  endtask

  task automatic test_writeback();
    logic seen;
    mem_txn_t obs, want;
    logic [31:0] wrd;
    next_cycle();
    rnd = 1'b0;
    drive_req(1'b0, 8'h00, 8'hA4, 32'h55555555);
    mem_q.push_back({1'b1, 8'h0E, 64'hAAAAAAAA_11111111});
    mem_q.push_back({1'b0, 8'hA4, 64'h0});
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b1 || o_hit !== 1'b0) begin
      failures++; $display("FAIL wb_miss got stall=%b hit=%b want 1 0", o_stall, o_hit);
    end
    next_cycle();
    idle_inputs();
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr || obs.data !== want.data) begin
      failures++;
      $display("FAIL wb_txn seen=%b got ty=%b addr=%h data=%h want ty=%b addr=%h data=%h",
               seen, obs.typ, obs.addr, obs.data, want.typ, want.addr, want.data);
    end
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '1;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr) begin
      failures++;
      $display("FAIL wb_read seen=%b got ty=%b addr=%h want ty=%b addr=%h", seen, obs.typ, obs.addr, want.typ, want.addr);
    end
    fill(8'hB0, 64'h99999999_88888888);
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b0 || o_stall !== 1'b1) begin
      failures++; $display("FAIL wrong_fill got ack=%b stall=%b want 0 1", o_mem_ack, o_stall);
    end
    fill(8'hA4, 64'h66666666_77777777);
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b1 || o_stall !== 1'b0) begin
      failures++; $display("FAIL wb_fill got ack=%b stall=%b want 1 0", o_mem_ack, o_stall);
    end
    next_cycle();
    drive_req(1'b0, 8'h00, 8'hA4, 32'h55555555);
    @(negedge clk);
    checks++;
    if (o_hit !== 1'b1) begin failures++; $display("FAIL wb_restore got hit=%b want=1", o_hit); end
    next_cycle();
    drive_req(1'b1, 8'h00, 8'hA4, 32'h0);
    rd_q.push_back(32'h55555555);
    @(negedge clk);
    wrd = rd_q.pop_front();
    checks++;
    if (o_read_data !== wrd) begin failures++; $display("FAIL wb_elem0 got=%h want=%h", o_read_data, wrd); end
    next_cycle();
    drive_req(1'b1, 8'h01, 8'hA4, 32'h0);
    rd_q.push_back(32'h66666666);
    @(negedge clk);
    wrd = rd_q.pop_front();
    checks++;
    if (o_read_data !== wrd) begin failures++; $display("FAIL wb_elem1 got=%h want=%h", o_read_data, wrd); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_miss();
    logic seen;
    mem_txn_t obs, want;
    next_cycle();
    drive_req(1'b1, 8'h02, 8'h30, 32'h0);
    mem_q.push_back({1'b0, 8'h30, 64'h0});
    @(negedge clk);
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '1;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr) begin
      failures++;
      $display("FAIL rmm_req seen=%b got ty=%b addr=%h want ty=%b addr=%h", seen, obs.typ, obs.addr, want.typ, want.addr);
    end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_hit, o_stall, o_read_data, o_mem_enable, o_mem_ack} !== '0) begin
      failures++; $display("FAIL rmm_during got hit=%b stall=%b en=%b ack=%b want 0", o_hit, o_stall, o_mem_enable, o_mem_ack);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_stall !== 1'b0 || o_mem_ack !== 1'b0) begin
      failures++; $display("FAIL rmm_idle got stall=%b ack=%b want 0 0", o_stall, o_mem_ack);
    end
    fill(8'h30, 64'hEEEEEEEE_FFFFFFFF);
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b0) begin failures++; $display("FAIL rmm_stale_fill got ack=%b want=0", o_mem_ack); end
    next_cycle();
    drive_req(1'b1, 8'h00, 8'hA4, 32'h0);
    mem_q.push_back({1'b0, 8'hA4, 64'h0});
    @(negedge clk);
    checks++;
    if (o_hit !== 1'b0 || o_stall !== 1'b1) begin
      failures++; $display("FAIL rmm_remiss got hit=%b stall=%b want 0 1", o_hit, o_stall);
    end
    wait_mem(seen, obs);
    want = (mem_q.size() > 0) ? mem_q.pop_front() : '1;
    checks++;
    if (!seen || obs.typ !== want.typ || obs.addr !== want.addr) begin
      failures++;
      $display("FAIL rmm_remiss_req seen=%b got ty=%b addr=%h want ty=%b addr=%h", seen, obs.typ, obs.addr, want.typ, want.addr);
    end
    fill(8'hA4, 64'h12345678_9ABCDEF0);
    @(negedge clk);
    checks++;
    if (o_mem_ack !== 1'b1 || o_read_data !== 32'h9ABCDEF0) begin
      failures++; $display("FAIL rmm_refill got ack=%b rd=%h want 1 9abcdef0", o_mem_ack, o_read_data);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_cold_fill();
    test_load_hit();
    test_miss_fill();
    test_store_hit();
    test_invalid_way();
    test_writeback();
    test_reset_mid_miss();
    checks++;
    if (mem_q.size() != 0 || rd_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got mem=%0d rd=%0d want 0 0", mem_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
